memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline stage directly downstream of the execute stage: consumes the 16-bit ALU result as a data-memory address or store operand and performs load, store, push, pop, and two-word call/return stack transfers. Owns a word-addressed data memory and the stack pointer. Produces registered load data and a reassembled 32-bit return PC for write-back and fetch. Stalls upstream for one cycle on two-word operations.

## Interface
- ADDR_WIDTH, 11, data-memory address width; depth 2^ADDR_WIDTH 16-bit words
- SP_RESET, 2^ADDR_WIDTH-1, stack pointer value after reset
- STACK_LIMIT, 2^(ADDR_WIDTH-1), lowest legal SP for a push, used only with guard enabled
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  operation present this cycle
- mem_op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET; 7 treated as NOP
- alu_result  in  16  execute-stage result; low ADDR_WIDTH bits are the LOAD/STORE address
- store_data  in  16  word written by STORE/PUSH
- pc_in  in  32  return address pushed by CALL
- stall  out  1  combinational; upstream holds all inputs while high
- out_valid  out  1  registered; one-cycle pulse per completed operation
- rdata  out  16  registered; LOAD/POP result
- pc_out  out  32  registered; RET-restored PC
- pc_out_valid  out  1  registered; one-cycle pulse with pc_out
- sp_out  out  ADDR_WIDTH  current stack pointer
- stack_fault  out  1  registered; sticky until reset (guard builds only, else tied 0)

## Operation
- Full descending stack; SP addresses next free word.
- LOAD: rdata <= mem[alu_result]. STORE: mem[alu_result] <= store_data.
- PUSH: mem[SP] <= store_data; SP <= SP-1. POP: rdata <= mem[SP+1]; SP <= SP+1.
- CALL: first cycle mem[SP] <= pc_in[31:16], SP-1; second cycle mem[SP] <= pc_in[15:0], SP-1.
- RET: first cycle pc_lo <= mem[SP+1], SP+1; second cycle pc_out <= {mem[SP+1], pc_lo}, SP+1.
- FSM states: IDLE, SECOND. IDLE -> SECOND when in_valid and mem_op is CALL/RET; SECOND -> IDLE unconditionally.
- stall = (state==IDLE) && in_valid && mem_op in {CALL, RET}; low in SECOND, so inputs are consumed at end of SECOND.
- SP arithmetic modulo 2^ADDR_WIDTH; upper alu_result bits ignored.
- in_valid low or NOP: no memory write, SP unchanged, out_valid 0.
- Memory read combinational within stage; all outputs registered.

## Timing
- Reset (rst low at edge): state IDLE, SP=SP_RESET, out_valid 0, rdata 0, pc_out 0, pc_out_valid 0, stack_fault 0, pc_lo 0. Memory contents not cleared.
- Single-word ops: accepted cycle N, out_valid/rdata valid cycle N+1.
- CALL/RET: stall high cycle N, SECOND in N+1, out_valid (and pc_out_valid for RET) in N+2.
- Back-to-back single-word ops sustain one per cycle; POP then LOAD of the same address sees the pre-POP memory (POP does not write).
- PUSH followed by POP next cycle returns the pushed word.
- Reset asserted while in SECOND: operation abandoned, first-word write already done remains in memory, SP returns to SP_RESET, no output pulse.
- in_valid dropped during a stalled cycle is a protocol violation; behaviour undefined.

## Configuration
- STACK_GUARD_EN defined: push-type word write with SP < STACK_LIMIT, or pop-type read with SP == SP_RESET, is suppressed (no write, SP unchanged) and sets stack_fault; CALL/RET second cycle checked independently; out_valid still pulses.
- Undefined: no checks, SP wraps silently, stack_fault constant 0.

## Test plan
- Reset: rst low 2 cycles -> sp_out=2047, all outputs 0, stall 0.
- STORE alu_result=0x0010 data=0xBEEF, then LOAD 0x0010 -> rdata=0xBEEF with out_valid one cycle after LOAD.
- PUSH 0x1234, PUSH 0x5678, POP, POP -> rdata 0x5678 then 0x1234; sp_out 2047 -> 2045 -> 2047.
- CALL pc_in=0x0001_00A0 -> stall one cycle, mem[2047]=0x0001, mem[2046]=0x00A0, sp_out=2045; then RET -> pc_out=0x000100A0, pc_out_valid pulse two cycles after RET presented, sp_out=2047.
- Reset during CALL SECOND cycle -> sp_out=2047, no out_valid, mem[2047]=high word.
- STACK_GUARD_EN: POP at SP=2047 -> stack_fault=1, sp_out stays 2047; without macro -> sp_out wraps to 0, stack_fault 0.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage: word-addressed data memory plus a full-descending stack with two-word CALL/RET transfers.
// Optional build macro STACK_GUARD_EN suppresses stack overflow/underflow accesses and raises a sticky stack_fault.
module memory_stage #(
  parameter int ADDR_WIDTH  = 11,
  parameter int SP_RESET    = 2**ADDR_WIDTH - 1,
  parameter int STACK_LIMIT = 2**(ADDR_WIDTH-1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [2:0]            mem_op,
  input  logic [15:0]           alu_result,
  input  logic [15:0]           store_data,
  input  logic [31:0]           pc_in,
  output logic                  stall,
  output logic                  out_valid,
  output logic [15:0]           rdata,
  output logic [31:0]           pc_out,
  output logic                  pc_out_valid,
  output logic [ADDR_WIDTH-1:0] sp_out,
  output logic                  stack_fault,
  output logic                  state_dbg
);

  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  localparam logic [2:0] OP_CALL  = 3'd5;
  localparam logic [2:0] OP_RET   = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] SP_INIT   = SP_RESET[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] SP_LIMIT  = STACK_LIMIT[ADDR_WIDTH-1:0];

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sp;
  logic [15:0]           pc_lo;
  logic                  ret_op;
  logic [15:0]           mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] addr, sp_inc, sp_dec, waddr;
  logic [15:0]           wdata;
  logic                  we, blocked, is_two;
  logic                  guard_push, guard_pop;
  logic                  unused_addr_hi;

  assign addr           = alu_result[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^alu_result[15:ADDR_WIDTH];
  assign sp_inc         = sp + 1'b1;
  assign sp_dec         = sp - 1'b1;
  assign sp_out         = sp;
  assign state_dbg      = state;

  // Handshake: an op is taken when in_valid is high and stall is low. A CALL/RET raises
  // stall in IDLE; upstream holds its inputs, and the op is consumed at the end of SECOND.
  assign is_two = in_valid && (mem_op == OP_CALL || mem_op == OP_RET);
  assign stall  = (state == IDLE) && is_two;

`ifdef STACK_GUARD_EN
  assign guard_push = (sp < SP_LIMIT);
  assign guard_pop  = (sp == SP_INIT);

  always_ff @(posedge clk) begin
    if (!rst)         stack_fault <= 1'b0;
    else if (blocked) stack_fault <= 1'b1;
  end
`else
  assign guard_push  = 1'b0;
  assign guard_pop   = 1'b0;
  assign stack_fault = 1'b0;
`endif

  always_comb begin
    we      = 1'b0;
    waddr   = sp;
    wdata   = store_data;
    blocked = 1'b0;
    if (state == SECOND) begin
      if (ret_op) begin
        blocked = guard_pop;
      end else begin
        blocked = guard_push;
        we      = !guard_push;
        wdata   = pc_in[15:0];
      end
    end else if (in_valid) begin
      case (mem_op)
        OP_STORE: begin
          we    = 1'b1;
          waddr = addr;
        end
        OP_PUSH: begin
          blocked = guard_push;
          we      = !guard_push;
        end
        OP_CALL: begin
          blocked = guard_push;
          we      = !guard_push;
          wdata   = pc_in[31:16];
        end
        OP_POP, OP_RET: blocked = guard_pop;
        default: ;
      endcase
    end
  end

  // Writes are gated by reset so a CALL abandoned in SECOND leaves only its first word.
  always_ff @(posedge clk) begin
    if (rst && we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      sp           <= SP_INIT;
      pc_lo        <= '0;
      ret_op       <= 1'b0;
      out_valid    <= 1'b0;
      rdata        <= '0;
      pc_out       <= '0;
      pc_out_valid <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      pc_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (mem_op)
              OP_LOAD: begin
                rdata     <= mem[addr];
                out_valid <= 1'b1;
              end
              OP_STORE: out_valid <= 1'b1;
              OP_PUSH: begin
                if (!blocked) sp <= sp_dec;
                out_valid <= 1'b1;
              end
              OP_POP: begin
                if (!blocked) begin
                  rdata <= mem[sp_inc];
                  sp    <= sp_inc;
                end
                out_valid <= 1'b1;
              end
              OP_CALL: begin
                if (!blocked) sp <= sp_dec;
                ret_op <= 1'b0;
                state  <= SECOND;
              end
              OP_RET: begin
                if (!blocked) begin
                  pc_lo <= mem[sp_inc];
                  sp    <= sp_inc;
                end
                ret_op <= 1'b1;
                state  <= SECOND;
              end
              default: ;
            endcase
          end
        end
        SECOND: begin
          state     <= IDLE;
          out_valid <= 1'b1;
          if (ret_op) begin
            pc_out_valid <= 1'b1;
            if (!blocked) begin
              pc_out <= {mem[sp_inc], pc_lo};
              sp     <= sp_inc;
            end
          end else if (!blocked) begin
            sp <= sp_dec;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized traffic
// checked against a stack/memory reference model.
module tb_memory_stage;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, STORE = 3'd2, PUSH = 3'd3,
                         POP = 3'd4, CALL = 3'd5, RET = 3'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  mem_op;
  logic [15:0] alu_result, store_data;
  logic [31:0] pc_in;
  logic        stall, out_valid, pc_out_valid, stack_fault, state_dbg;
  logic [15:0] rdata;
  logic [31:0] pc_out;
  logic [10:0] sp_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] ref_mem [int];
  logic [10:0] ref_sp;

  memory_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_op(mem_op),
    .alu_result(alu_result), .store_data(store_data), .pc_in(pc_in),
    .stall(stall), .out_valid(out_valid), .rdata(rdata), .pc_out(pc_out),
    .pc_out_valid(pc_out_valid), .sp_out(sp_out), .stack_fault(stack_fault),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    in_valid = 1'b0; mem_op = NOP; alu_result = '0; store_data = '0; pc_in = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ref_sp = 11'd2047;
    exp_q.delete();
  endtask

  // Issue one single-word op at a negedge; check its result at the next negedge.
  task automatic single_op(input logic v, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] d);
    logic eff, have_exp;
    logic [15:0] e;
    int key;
    eff = v && (op >= LOAD) && (op <= POP);
    have_exp = 1'b0;
    if (eff) begin
      case (op)
        LOAD: begin
          key = int'(a[10:0]);
          if (ref_mem.exists(key)) begin exp_q.push_back(ref_mem[key]); have_exp = 1'b1; end
        end
        STORE: ref_mem[int'(a[10:0])] = d;
        PUSH: begin ref_mem[int'(ref_sp)] = d; ref_sp = ref_sp - 11'd1; end
        POP: begin
          ref_sp = ref_sp + 11'd1;
          key = int'(ref_sp);
          if (ref_mem.exists(key)) begin exp_q.push_back(ref_mem[key]); have_exp = 1'b1; end
        end
        default: ;
      endcase
    end
    in_valid = v; mem_op = op; alu_result = a; store_data = d;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL single_stall: got %b expected 0", stall); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== eff) begin n_fail++; $display("FAIL out_valid op=%0d: got %b expected %b", op, out_valid, eff); end
    n_checks++;
    if (sp_out !== ref_sp) begin n_fail++; $display("FAIL sp_out op=%0d: got %0d expected %0d", op, sp_out, ref_sp); end
    if (have_exp) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rdata !== e) begin n_fail++; $display("FAIL rdata op=%0d: got %h expected %h", op, rdata, e); end
    end
    idle_inputs();
  endtask

  task automatic two_op(input logic is_ret, input logic [31:0] pc);
    logic [15:0] lo, hi;
    logic known;
    known = 1'b0; lo = '0; hi = '0;
    if (!is_ret) begin
      ref_mem[int'(ref_sp)] = pc[31:16]; ref_sp = ref_sp - 11'd1;
      ref_mem[int'(ref_sp)] = pc[15:0];  ref_sp = ref_sp - 11'd1;
    end else begin
      ref_sp = ref_sp + 11'd1;
      known = ref_mem.exists(int'(ref_sp));
      if (known) lo = ref_mem[int'(ref_sp)];
      ref_sp = ref_sp + 11'd1;
      known = known && ref_mem.exists(int'(ref_sp));
      if (known) hi = ref_mem[int'(ref_sp)];
    end
    in_valid = 1'b1; mem_op = is_ret ? RET : CALL; pc_in = pc;
    alu_result = 16'($urandom); store_data = 16'($urandom);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL two_stall_first: got %b expected 1", stall); end
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL two_stall_second: got %b expected 0", stall); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL two_early_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (state_dbg !== 1'b1) begin n_fail++; $display("FAIL two_state: got %b expected 1", state_dbg); end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL two_out_valid: got %b expected 1", out_valid); end
    n_checks++;
    if (pc_out_valid !== is_ret) begin n_fail++; $display("FAIL pc_out_valid: got %b expected %b", pc_out_valid, is_ret); end
    n_checks++;
    if (sp_out !== ref_sp) begin n_fail++; $display("FAIL two_sp: got %0d expected %0d", sp_out, ref_sp); end
    if (is_ret && known) begin
      n_checks++;
      if (pc_out !== {hi, lo}) begin n_fail++; $display("FAIL pc_out: got %h expected %h", pc_out, {hi, lo}); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sp_out !== 11'd2047) begin n_fail++; $display("FAIL reset_sp: got %0d expected 2047", sp_out); end
    n_checks++;
    if ({out_valid, pc_out_valid, stack_fault, stall} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {out_valid, pc_out_valid, stack_fault, stall});
    end
    n_checks++;
    if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
    n_checks++;
    if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
    rst = 1'b1;
    ref_sp = 11'd2047;
  endtask

  task automatic test_store_load();
    single_op(1'b1, STORE, 16'h0010, 16'hBEEF);
    single_op(1'b1, LOAD,  16'h0010, 16'h0000);
    single_op(1'b1, STORE, 16'hF820, 16'h5A5A);  // upper address bits ignored
    single_op(1'b1, LOAD,  16'h0020, 16'h0000);
    single_op(1'b1, NOP,   16'h0020, 16'h1111);
    single_op(1'b1, 3'd7,  16'h0020, 16'h2222);
    single_op(1'b0, STORE, 16'h0020, 16'h3333);
    single_op(1'b1, LOAD,  16'h0020, 16'h0000);
  endtask

  task automatic test_push_pop();
    single_op(1'b1, PUSH, 16'h0, 16'h1234);
    single_op(1'b1, PUSH, 16'h0, 16'h5678);
    single_op(1'b1, POP,  16'h0, 16'h0);
    single_op(1'b1, POP,  16'h0, 16'h0);
    single_op(1'b1, LOAD, 16'h07FF, 16'h0);  // POP leaves memory intact
    single_op(1'b1, PUSH, 16'h0, 16'h9ABC);
    single_op(1'b1, POP,  16'h0, 16'h0);
  endtask

  task automatic test_call_ret();
    two_op(1'b0, 32'h0001_00A0);
    single_op(1'b1, LOAD, 16'h07FF, 16'h0);
    single_op(1'b1, LOAD, 16'h07FE, 16'h0);
    two_op(1'b1, 32'h0);
  endtask

  task automatic test_reset_in_second();
    single_op(1'b1, STORE, 16'h07FE, 16'hAAAA);
    in_valid = 1'b1; mem_op = CALL; pc_in = 32'hCAFE_1234;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (sp_out !== 11'd2047) begin n_fail++; $display("FAIL abort_sp: got %0d expected 2047", sp_out); end
    rst = 1'b1;
    idle_inputs();
    ref_sp = 11'd2047;
    ref_mem[2047] = 16'hCAFE;
    @(negedge clk);
    n_checks++;
    if (pc_out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_pc_valid: got %b expected 0", pc_out_valid); end
    single_op(1'b1, LOAD, 16'h07FF, 16'h0);
    single_op(1'b1, LOAD, 16'h07FE, 16'h0);
  endtask

  task automatic test_underflow();
    apply_reset();
    single_op(1'b1, STORE, 16'h0000, 16'h0F0F);
    in_valid = 1'b1; mem_op = POP;
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL underflow_valid: got %b expected 1", out_valid); end
`ifdef STACK_GUARD_EN
    n_checks++;
    if (sp_out !== 11'd2047) begin n_fail++; $display("FAIL underflow_sp: got %0d expected 2047", sp_out); end
    n_checks++;
    if (stack_fault !== 1'b1) begin n_fail++; $display("FAIL underflow_fault: got %b expected 1", stack_fault); end
`else
    n_checks++;
    if (sp_out !== 11'd0) begin n_fail++; $display("FAIL underflow_sp: got %0d expected 0", sp_out); end
    n_checks++;
    if (stack_fault !== 1'b0) begin n_fail++; $display("FAIL underflow_fault: got %b expected 0", stack_fault); end
    n_checks++;
    if (rdata !== 16'h0F0F) begin n_fail++; $display("FAIL underflow_rdata: got %h expected 0f0f", rdata); end
`endif
    apply_reset();
  endtask

  task automatic test_random();
    int depth, pick;
    for (int i = 0; i < 300; i++) begin
      depth = int'(11'd2047 - ref_sp);
      pick  = $urandom_range(0, 9);
      case (pick)
        0, 1: single_op(1'b1, STORE, 16'($urandom_range(0, 63)) | 16'($urandom_range(0, 31) << 11), 16'($urandom));
        2, 3: single_op(1'b1, LOAD,  16'($urandom_range(0, 63)), 16'($urandom));
        4:    if (depth < 30) single_op(1'b1, PUSH, 16'($urandom), 16'($urandom));
        5:    if (depth >= 1) single_op(1'b1, POP, 16'($urandom), 16'($urandom));
        6:    if (depth <= 28) two_op(1'b0, $urandom);
        7:    if (depth >= 2) two_op(1'b1, 32'h0);
        8:    single_op(1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        default: single_op(1'b1, ($urandom_range(0, 1) == 0) ? NOP : 3'd7, 16'($urandom), 16'($urandom));
      endcase
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    ref_sp = 11'd2047;
    test_reset();
    test_store_load();
    test_push_pop();
    test_call_ret();
    test_reset_in_second();
    test_underflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
